// File: rtl/pi_pkg.sv
// Shared types and helpers for the multi-channel PI controller.
package pi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Clamp a wide signed value into the signed range of a w-bit word.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/pi_channel_datapath.sv
// Combinational PI step for one channel: error, saturated integral candidate,
// scaled and clamped output, and anti-windup integral selection.
module pi_channel_datapath
    import pi_pkg::*;
#(
    parameter int W    = 8,
    parameter int KW   = 8,
    parameter int IW   = 16,
    parameter int FRAC = 0
) (
    input  logic signed [W-1:0]  current,
    input  logic signed [W-1:0]  desired,
    input  logic [KW-1:0]        kp,
    input  logic [KW-1:0]        ki,
    input  logic signed [IW-1:0] integ,
    output logic signed [W-1:0]  result,
    output logic                 clamped,
    output logic signed [IW-1:0] integ_next
);

    logic signed [W:0]  err;
    logic signed [63:0] cand;
    logic signed [63:0] sum;
    logic signed [63:0] shifted;
    logic signed [63:0] clamp;

    always_comb begin
        err     = (W+1)'(desired) - (W+1)'(current);
        cand    = saturate(longint'(integ) + longint'(err), IW);
        sum     = longint'($signed({1'b0, kp})) * longint'(err)
                + longint'($signed({1'b0, ki})) * cand;
        shifted = sum >>> FRAC;
        clamp   = saturate(shifted, W);
        clamped = (clamp != shifted);
        result  = clamp[W-1:0];
        // Freeze the integrator only when the error pushes further into the clamp.
        if (clamped && (((shifted > clamp) && (err > 0)) || ((shifted < clamp) && (err < 0))))
            integ_next = integ;
        else
            integ_next = cand[IW-1:0];
    end

endmodule

// File: rtl/pi_multi_channel.sv
// N-channel PI controller sharing one datapath; channels processed one per cycle,
// done pulses N_CH+1 cycles after start; start while busy is dropped.
module pi_multi_channel
    import pi_pkg::*;
#(
    parameter int W    = 8,
    parameter int N_CH = 4,
    parameter int KW   = 8,
    parameter int IW   = 16,
    parameter int FRAC = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [N_CH*W-1:0]   current_value,
    input  logic [N_CH*W-1:0]   desired_value,
    input  logic [KW-1:0]       kp,
    input  logic [KW-1:0]       ki,
    input  logic [N_CH-1:0]     ch_enable,
    input  logic                clear_int,
    output logic                busy,
    output logic                done,
    output logic [N_CH*W-1:0]   pi_result,
    output logic [N_CH-1:0]     sat
);

    localparam int IDXW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(N_CH - 1);

    state_t                state;
    state_t                state_next;
    logic [IDXW-1:0]       idx;
    logic [N_CH*W-1:0]     cur_q;
    logic [N_CH*W-1:0]     des_q;
    logic [KW-1:0]         kp_q;
    logic [KW-1:0]         ki_q;
    logic [N_CH-1:0]       en_q;
    logic [N_CH*W-1:0]     result_q;
    logic [N_CH-1:0]       sat_q;
    logic signed [IW-1:0]  integ [N_CH];

    logic signed [W-1:0]   ch_result;
    logic                  ch_sat;
    logic signed [IW-1:0]  ch_integ_next;

    pi_channel_datapath #(
        .W    (W),
        .KW   (KW),
        .IW   (IW),
        .FRAC (FRAC)
    ) u_dp (
        .current    ($signed(cur_q[idx*W +: W])),
        .desired    ($signed(des_q[idx*W +: W])),
        .kp         (kp_q),
        .ki         (ki_q),
        .integ      (integ[idx]),
        .result     (ch_result),
        .clamped    (ch_sat),
        .integ_next (ch_integ_next)
    );

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (start) state_next = CALC;
            CALC: begin
                busy = 1'b1;
                if (idx == LAST) state_next = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            cur_q    <= '0;
            des_q    <= '0;
            kp_q     <= '0;
            ki_q     <= '0;
            en_q     <= '0;
            result_q <= '0;
            sat_q    <= '0;
            for (int k = 0; k < N_CH; k++) integ[k] <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && start) begin
                cur_q <= current_value;
                des_q <= desired_value;
                kp_q  <= kp;
                ki_q  <= ki;
                en_q  <= ch_enable;
                idx   <= '0;
            end
            if (state == CALC) begin
                idx <= (idx == LAST) ? '0 : idx + 1'b1;
                if (en_q[idx]) begin
                    result_q[idx*W +: W] <= ch_result;
                    sat_q[idx]           <= ch_sat;
                end
            end
            // A clear overrides any integrator write in the same cycle.
            for (int k = 0; k < N_CH; k++) begin
                if (clear_int)
                    integ[k] <= '0;
                else if (state == CALC && en_q[idx] && idx == IDXW'(k))
                    integ[k] <= ch_integ_next;
            end
        end
    end

    assign pi_result = result_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_pi_multi_channel.sv
// Directed bench for pi_multi_channel with hand-computed expectations (kp=ki=2).
module tb_pi_multi_channel;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] current_value;
    logic [31:0] desired_value;
    logic [7:0]  kp;
    logic [7:0]  ki;
    logic [3:0]  ch_enable;
    logic        clear_int;
    logic        busy;
    logic        done;
    logic [31:0] pi_result;
    logic [3:0]  sat;

    int n_cmp  = 0;
    int n_fail = 0;

    pi_multi_channel #(.W(8), .N_CH(4), .KW(8), .IW(16), .FRAC(0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .current_value (current_value),
        .desired_value (desired_value),
        .kp            (kp),
        .ki            (ki),
        .ch_enable     (ch_enable),
        .clear_int     (clear_int),
        .busy          (busy),
        .done          (done),
        .pi_result     (pi_result),
        .sat           (sat)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start, wait (bounded) for done, and check latency and the done-cycle busy.
    task automatic run_update(input string tag);
        int cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy_after_start"}, 64'(busy), 64'd1);
        cyc = 0;
        while (!done && cyc < 20) begin
            tick();
            cyc++;
        end
        chk({tag, "_done_latency"}, 64'(cyc), 64'd4);
        chk({tag, "_busy_in_done"}, 64'(busy), 64'd1);
        tick();
        chk({tag, "_done_one_cycle"}, 64'({busy, done}), 64'd0);
    endtask

    initial begin
        int dones;
        rst_n = 1'b0; start = 1'b0; clear_int = 1'b0;
        current_value = '0; desired_value = '0;
        kp = 8'd2; ki = 8'd2; ch_enable = 4'hF;
        tick(); tick();
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_result", 64'(pi_result), 64'd0);
        chk("reset_sat", 64'(sat), 64'd0);
        rst_n = 1'b1;
        tick();

        // error 6, integral 6: 2*6 + 2*6 = 24
        desired_value = {4{8'd10}};
        current_value = {4{8'd4}};
        run_update("first");
        chk("first_result", 64'(pi_result), 64'h18181818);
        chk("first_sat", 64'(sat), 64'h0);

        // integral 12: 12 + 24 = 36
        run_update("second");
        chk("second_result", 64'(pi_result), 64'h24242424);

        // positive clamp on ch0, negative clamp on ch1, from zero state
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        desired_value = {8'd0, 8'd0, 8'h80, 8'h7F};
        current_value = {8'd0, 8'd0, 8'h7F, 8'h80};
        run_update("clamp");
        chk("clamp_result", 64'(pi_result), 64'h0000807F);
        chk("clamp_sat", 64'(sat), 64'h3);
        // zero error: result equals 2*integral, so 0 proves the integrals were frozen
        desired_value = '0;
        current_value = '0;
        run_update("antiwindup");
        chk("antiwindup_result", 64'(pi_result), 64'h0);
        chk("antiwindup_sat", 64'(sat), 64'h0);

        // start re-pulsed during CALC must not queue a second update
        desired_value = {4{8'd10}};
        current_value = {4{8'd4}};
        start = 1'b1;
        tick();
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            start = (i == 1);
            if (done) dones++;
            tick();
        end
        start = 1'b0;
        chk("ignored_start_dones", 64'(dones), 64'd1);
        chk("ignored_start_result", 64'(pi_result), 64'h18181818);

        // clear then same error: integral restarts at 6 -> 24 rather than 36
        clear_int = 1'b1; tick(); clear_int = 1'b0;
        run_update("cleared");
        chk("cleared_result", 64'(pi_result), 64'h18181818);

        // partial enable, integrals 6: ch0/ch2 error 16 -> cand 22 -> 32+44 = 76
        desired_value = {4{8'd20}};
        ch_enable = 4'b0101;
        start = 1'b1;
        tick();
        start = 1'b0;
        desired_value = '0;
        ch_enable = 4'hF;
        tick(); tick(); tick(); tick();
        chk("mask_done", 64'(done), 64'd1);
        tick();
        chk("mask_result", 64'(pi_result), 64'h184C184C);
        // zero error exposes integrals: ch0/ch2 = 22 -> 44, ch1/ch3 = 6 -> 12
        desired_value = current_value;
        run_update("mask_hold");
        chk("mask_hold_result", 64'(pi_result), 64'h0C2C0C2C);

        // reset in the second CALC cycle aborts the update
        desired_value = {4{8'd10}};
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_result", 64'(pi_result), 64'h0);
        chk("abort_sat", 64'(sat), 64'h0);
        chk("abort_busy", 64'(busy), 64'd0);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) dones++;
            tick();
        end
        chk("abort_no_done", 64'(dones), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pi_multi_channel.md
PI_MULTI_CHANNEL -- requirements
Module: pi_multi_channel

Interface
REQ-001 Parameter W, default 8: signed data width of each channel's current, desired and result value.
REQ-002 Parameter N_CH, default 4: number of controller channels.
REQ-003 Parameter KW, default 8: unsigned gain width.
REQ-004 Parameter IW, default 16: signed integrator width per channel.
REQ-005 Parameter FRAC, default 0: arithmetic right-shift applied to the P+I sum (fixed-point gains).
REQ-006 Port clk, input, 1: single clock; all logic on rising edge.
REQ-007 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-008 Port start, input, 1: request one update of all channels.
REQ-009 Port current_value, input, N_CH*W: packed signed measurements; channel k at bits [k*W +: W].
REQ-010 Port desired_value, input, N_CH*W: packed signed setpoints, same packing.
REQ-011 Port kp, input, KW: unsigned proportional gain.
REQ-012 Port ki, input, KW: unsigned integral gain.
REQ-013 Port ch_enable, input, N_CH: per-channel enable mask.
REQ-014 Port clear_int, input, 1: synchronous clear of all integrators.
REQ-015 Port busy, output, 1: high while an update is in progress.
REQ-016 Port done, output, 1: one-cycle pulse when all channels are updated.
REQ-017 Port pi_result, output, N_CH*W: packed signed controller outputs.
REQ-018 Port sat, output, N_CH: per-channel flag, set when that channel's last result was clamped.

Function
REQ-019 FSM states: IDLE, CALC, DONE; IDLE->CALC on start; CALC->DONE after channel N_CH-1; DONE->IDLE unconditionally.
REQ-020 In IDLE, start SHALL snapshot current_value, desired_value, kp, ki and ch_enable into internal registers; later input changes do not affect the update in progress.
REQ-021 start while busy SHALL be ignored (no queuing).
REQ-022 CALC SHALL process one channel per cycle, index 0..N_CH-1, through a single shared datapath.
REQ-023 done SHALL pulse exactly N_CH+1 cycles after the start cycle; busy is high from the cycle after start through the done cycle.
REQ-024 error = desired - current, computed signed at W+1 bits (no overflow).
REQ-025 Candidate integral = integral + error, saturated to [-2^(IW-1), 2^(IW-1)-1].
REQ-026 sum = kp*error + ki*candidate, computed at full width (signed), then >>> FRAC, then clamped to [-2^(W-1), 2^(W-1)-1].
REQ-027 Anti-windup: if the result clamps and error has the same sign as the clamp direction, the integral register keeps its old value; otherwise it takes the candidate.
REQ-028 pi_result[k] and sat[k] SHALL update in the cycle channel k is processed; other channels hold.
REQ-029 Channel with snapshot ch_enable[k]=0 SHALL hold its integral, result and sat flag.
REQ-030 clear_int SHALL zero all integrators the next cycle; pi_result and sat are unaffected. If clear_int coincides with a channel update, the clear wins for the integral and the result uses the candidate.

Reset
REQ-031 When rst_n=0 at a clock edge: FSM->IDLE, busy=0, done=0, pi_result=0, sat=0, all integrators=0, channel index=0.
REQ-032 Reset during CALC SHALL abort the update; no done pulse for that update.

Structure
REQ-033 Package pi_pkg SHALL hold the FSM state enum and a signed saturate function used for both integral and output clamping.
REQ-034 Sub-module pi_channel_datapath SHALL be the combinational error/candidate/sum/clamp/anti-windup datapath for one channel, instantiated once.

Verification (N_CH=4, W=8, KW=8, IW=16, FRAC=0, kp=ki=2, all enabled)
REQ-035 After reset, start with desired=10 and current=4 on all channels -> error 6, integral 6, every pi_result=24, sat=0, done 5 cycles after start.
REQ-036 Second start with the same inputs -> integral 12, every pi_result=36.
REQ-037 Channel 0 desired=127, current=-128 from zero state -> pi_result[0]=127, sat[0]=1, integral[0] remains 0 (anti-windup).
REQ-038 start pulsed again during CALC -> ignored, exactly one done. clear_int then start with error 6 -> pi_result=24.
REQ-039 ch_enable=4'b0101 -> channels 1 and 3 hold their previous result and integral; channels 0 and 2 update.
REQ-040 rst_n low for one cycle in the 2nd CALC cycle -> all outputs 0, busy=0, no done pulse.
